// File: rtl/uart_ctrl_pkg.sv
// Shared encodings for the UART slave-port arbiter: FSM states, op codes, grant patterns.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    function automatic logic [1:0] gnt_onehot(input logic owner);
        return owner ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever was not last served.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       valid_c,
    output logic       pick_c
);

    always_comb begin
        valid_c = |req;
        pick_c  = 1'b0;
        case (req)
            2'b01:   pick_c = 1'b0;
            2'b10:   pick_c = 1'b1;
            2'b11:   pick_c = ~last_owner;
            default: pick_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the UART memory-mapped slave port between the core (m0) and the CI controller (m1),
// one transaction at a time with round-robin fairness and the slave's post-response gap.
module uart_bus_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEFAULT_PRIO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [DATA_WIDTH-1:0] m0_write_data,
    output logic [DATA_WIDTH-1:0] m0_read_data,
    output logic                  m0_response,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [DATA_WIDTH-1:0] m1_write_data,
    output logic [DATA_WIDTH-1:0] m1_read_data,
    output logic                  m1_response,
    output logic                  uart_read,
    output logic                  uart_write,
    output logic [ADDR_WIDTH-1:0] uart_address,
    output logic [DATA_WIDTH-1:0] uart_write_data,
    input  logic [DATA_WIDTH-1:0] uart_read_data,
    input  logic                  uart_response,
    output logic [1:0]            grant,
    output logic                  busy
);

    state_t                  state;
    logic                    last_owner;
    logic                    owner;
    logic                    arb_valid_c;
    logic                    arb_pick_c;
    logic                    sel_op_c;
    logic [ADDR_WIDTH-1:0]   sel_address_c;
    logic [DATA_WIDTH-1:0]   sel_write_data_c;

    rr_arbiter2 u_rr (
        .req        ({m1_read | m1_write, m0_read | m0_write}),
        .last_owner (last_owner),
        .valid_c    (arb_valid_c),
        .pick_c     (arb_pick_c)
    );

    // Payload of the winning requester; write dominates when read and write are both raised.
    always_comb begin
        sel_op_c         = OP_READ;
        sel_address_c    = m0_address;
        sel_write_data_c = m0_write_data;
        if (arb_pick_c) begin
            sel_op_c         = m1_write ? OP_WRITE : OP_READ;
            sel_address_c    = m1_address;
            sel_write_data_c = m1_write_data;
        end else begin
            sel_op_c         = m0_write ? OP_WRITE : OP_READ;
        end
    end

    // The command pulse is launched on the grant edge so it is visible during ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            last_owner      <= ~1'(DEFAULT_PRIO);
            owner           <= 1'b0;
            grant           <= GNT_NONE;
            busy            <= 1'b0;
            uart_read       <= 1'b0;
            uart_write      <= 1'b0;
            uart_address    <= '0;
            uart_write_data <= '0;
            m0_read_data    <= '0;
            m1_read_data    <= '0;
            m0_response     <= 1'b0;
            m1_response     <= 1'b0;
        end else begin
            uart_read   <= 1'b0;
            uart_write  <= 1'b0;
            m0_response <= 1'b0;
            m1_response <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid_c) begin
                        owner           <= arb_pick_c;
                        last_owner      <= arb_pick_c;
                        grant           <= gnt_onehot(arb_pick_c);
                        busy            <= 1'b1;
                        uart_address    <= sel_address_c;
                        uart_write_data <= sel_write_data_c;
                        uart_write      <= (sel_op_c == OP_WRITE);
                        uart_read       <= (sel_op_c == OP_READ);
                        state           <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (uart_response) begin
                        if (owner) begin
                            m1_read_data <= uart_read_data;
                            m1_response  <= 1'b1;
                        end else begin
                            m0_read_data <= uart_read_data;
                            m0_response  <= 1'b1;
                        end
                        state <= GAP;
                    end
                end
                GAP: begin
                    grant <= GNT_NONE;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: vector table, corner-case sequences, and a
// randomized run against a transaction-level reference model.
module tb_uart_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [AW-1:0] m0_address, m1_address, uart_address;
    logic [DW-1:0] m0_write_data, m1_write_data, m0_read_data, m1_read_data;
    logic          m0_response, m1_response;
    logic          uart_read, uart_write, uart_response;
    logic [DW-1:0] uart_write_data, uart_read_data;
    logic [1:0]    grant;
    logic          busy;

    uart_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEFAULT_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_write_data(m0_write_data), .m0_read_data(m0_read_data), .m0_response(m0_response),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_write_data(m1_write_data), .m1_read_data(m1_read_data), .m1_response(m1_response),
        .uart_read(uart_read), .uart_write(uart_write), .uart_address(uart_address),
        .uart_write_data(uart_write_data), .uart_read_data(uart_read_data),
        .uart_response(uart_response), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_rdata [2];

    typedef struct {
        logic          who;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        int            lat;
        logic [DW-1:0] rdata;
        logic          exp_rd;
        logic          exp_wr;
        logic [1:0]    exp_gnt;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_write_data = '0;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_write_data = '0;
        uart_response = 0; uart_read_data = '0;
    endtask

    task automatic set_req(input logic who, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who) begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_write_data = d;
        end else begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_write_data = d;
        end
    endtask

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // One complete transaction from a lone requester, starting and ending in IDLE.
    task automatic run_txn(input vec_t v);
        set_req(v.who, v.rd, v.wr, v.addr, v.wd);
        tick();
        chk("txn_uart_read", uart_read, v.exp_rd);
        chk("txn_uart_write", uart_write, v.exp_wr);
        chk("txn_grant", grant, v.exp_gnt);
        chk("txn_addr", uart_address, v.addr);
        chk("txn_wdata", uart_write_data, v.wd);
        chk("txn_busy", busy, 1);
        for (int k = 0; k < v.lat; k++) begin
            tick();
            chk("hold_pulses", {uart_read, uart_write}, 0);
            chk("hold_addr", uart_address, v.addr);
            chk("hold_wdata", uart_write_data, v.wd);
            chk("hold_grant", grant, v.exp_gnt);
        end
        uart_response = 1; uart_read_data = v.rdata;
        tick();
        uart_response = 0; uart_read_data = '0;
        exp_rdata[v.who] = v.rdata;
        chk("resp_owner", v.who ? m1_response : m0_response, 1);
        chk("resp_other", v.who ? m0_response : m1_response, 0);
        chk("rdata_owner", v.who ? m1_read_data : m0_read_data, exp_rdata[v.who]);
        chk("rdata_other", v.who ? m0_read_data : m1_read_data, exp_rdata[~v.who]);
        set_req(v.who, 0, 0, '0, '0);
        tick();
        chk("post_idle", {busy, grant, m0_response, m1_response}, 0);
    endtask

    // Reference model state for the randomized run.
    bit          mo_out, mo_owner, mo_last, resp_now;
    int          elig, wait_from;
    logic [AW-1:0] mo_addr;
    logic [DW-1:0] mo_wd;
    bit          x_rd, x_wr, x_r0, x_r1, x_busy, x_hold;
    logic [1:0]  x_gnt;
    logic [DW-1:0] x_d0, x_d1;
    bit          act [2];
    bit          q_rd [2], q_wr [2];
    logic [AW-1:0] q_addr [2];
    logic [DW-1:0] q_wd [2];
    bit          s_pend;
    int          s_cnt;

    initial begin
        idle_inputs();
        reset = 1;
        tick(); tick();
        chk("reset_outs", {uart_read, uart_write, m0_response, m1_response, busy, grant}, 0);
        chk("reset_bus", {uart_address, uart_write_data}, 0);
        chk("reset_rdata", {m0_read_data, m1_read_data}, 0);
        exp_rdata[0] = '0; exp_rdata[1] = '0;

        // Contention straight after reset: m0 first, then strict alternation.
        reset = 0;
        set_req(0, 1, 0, 32'h10, '0);
        set_req(1, 1, 0, 32'h20, '0);
        for (int k = 0; k < 4; k++) begin
            logic w;
            w = 1'(k % 2);
            tick();
            chk("rr_grant", grant, onehot(w));
            chk("rr_pulse", {uart_read, uart_write}, 2'b10);
            chk("rr_addr", uart_address, w ? 32'h20 : 32'h10);
            tick();
            uart_response = 1; uart_read_data = 32'h100 + 32'(k);
            tick();
            uart_response = 0;
            exp_rdata[w] = 32'h100 + 32'(k);
            chk("rr_resp", {m1_response, m0_response}, onehot(w));
            chk("rr_rdata", w ? m1_read_data : m0_read_data, exp_rdata[w]);
            chk("rr_gap_busy", busy, 1);
            set_req(w, 0, 0, '0, '0);
            tick();
            chk("rr_idle", {busy, grant}, 0);
            if (k < 3) set_req(w, 1, 0, w ? 32'h20 : 32'h10, '0);
            else idle_inputs();
        end
        tick();
        chk("rr_drained", {busy, uart_read, uart_write}, 0);

        vecs[0] = '{who:0, rd:1, wr:0, addr:32'h4,   wd:32'h0,        lat:1, rdata:32'h1,        exp_rd:1, exp_wr:0, exp_gnt:2'b01};
        vecs[1] = '{who:1, rd:0, wr:1, addr:32'h100, wd:32'hA5000000, lat:3, rdata:32'h77,       exp_rd:0, exp_wr:1, exp_gnt:2'b10};
        vecs[2] = '{who:0, rd:1, wr:1, addr:32'h8,   wd:32'h12345678, lat:2, rdata:32'h55,       exp_rd:0, exp_wr:1, exp_gnt:2'b01};
        vecs[3] = '{who:1, rd:1, wr:0, addr:32'hC,   wd:32'h0,        lat:1, rdata:32'hCAFEF00D, exp_rd:1, exp_wr:0, exp_gnt:2'b10};
        for (int i = 0; i < 4; i++) run_txn(vecs[i]);

        // Stray slave response while idle must be ignored.
        uart_response = 1; uart_read_data = 32'hDEAD;
        tick();
        uart_response = 0; uart_read_data = '0;
        chk("stray_resp", {m0_response, m1_response, busy}, 0);
        chk("stray_rdata", {m0_read_data, m1_read_data}, {exp_rdata[0], exp_rdata[1]});
        tick();
        chk("stray_still_idle", {busy, grant, uart_read, uart_write}, 0);
        run_txn(vecs[0]);

        // Reset while waiting on the slave.
        set_req(0, 1, 0, 32'h30, '0);
        tick(); tick();
        chk("pre_reset_busy", busy, 1);
        reset = 1;
        tick();
        chk("rst_wait_ctl", {busy, grant, uart_read, uart_write, m0_response, m1_response}, 0);
        chk("rst_wait_data", {uart_address, m0_read_data, m1_read_data}, 0);
        reset = 0;
        idle_inputs();
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        run_txn(vecs[1]);

        // Randomized run against the transaction-level model.
        reset = 1;
        tick(); tick();
        reset = 0;
        idle_inputs();
        mo_out = 0; mo_owner = 0; mo_last = 1; elig = 0; wait_from = 0;
        x_d0 = '0; x_d1 = '0; s_pend = 0; s_cnt = 0;
        mo_addr = '0; mo_wd = '0;
        for (int m = 0; m < 2; m++) begin
            act[m] = 0; q_rd[m] = 0; q_wr[m] = 0; q_addr[m] = '0; q_wd[m] = '0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) begin
                tick();
                chk("rnd_pulses", {uart_read, uart_write}, {x_rd, x_wr});
                chk("rnd_resp", {m0_response, m1_response}, {x_r0, x_r1});
                chk("rnd_rdata", {m0_read_data, m1_read_data}, {x_d0, x_d1});
                chk("rnd_busy_grant", {busy, grant}, {x_busy, x_gnt});
                if (x_hold) chk("rnd_bus", {uart_address, uart_write_data}, {mo_addr, mo_wd});
            end
            for (int m = 0; m < 2; m++) begin
                if (act[m] && (m == 0 ? m0_response : m1_response)) begin
                    act[m] = 0;
                end else if (!act[m] && ($urandom % 3 == 0)) begin
                    int c;
                    c = int'($urandom_range(0, 2));
                    act[m] = 1;
                    q_rd[m] = (c != 1);
                    q_wr[m] = (c != 0);
                    q_addr[m] = $urandom;
                    q_wd[m] = $urandom;
                end
            end
            set_req(0, act[0] & q_rd[0], act[0] & q_wr[0], q_addr[0], q_wd[0]);
            set_req(1, act[1] & q_rd[1], act[1] & q_wr[1], q_addr[1], q_wd[1]);
            uart_response = 0;
            if (uart_read | uart_write) begin
                s_pend = 1;
                s_cnt = int'($urandom_range(1, 4));
            end else if (s_pend) begin
                s_cnt--;
                if (s_cnt == 0) begin
                    s_pend = 0;
                    uart_response = 1;
                    uart_read_data = $urandom;
                end
            end else if ($urandom % 8 == 0) begin
                uart_response = 1;
                uart_read_data = $urandom;
            end
            x_rd = 0; x_wr = 0; x_r0 = 0; x_r1 = 0; resp_now = 0;
            if (mo_out && uart_response && cyc >= wait_from) begin
                resp_now = 1;
                mo_out = 0;
                elig = cyc + 2;
                if (mo_owner) begin x_r1 = 1; x_d1 = uart_read_data; end
                else begin x_r0 = 1; x_d0 = uart_read_data; end
            end else if (!mo_out && cyc >= elig && (act[0] || act[1])) begin
                mo_owner = (act[0] && act[1]) ? !mo_last : act[1];
                mo_last = mo_owner;
                mo_out = 1;
                wait_from = cyc + 2;
                x_wr = q_wr[mo_owner];
                x_rd = !q_wr[mo_owner];
                mo_addr = q_addr[mo_owner];
                mo_wd = q_wd[mo_owner];
            end
            x_busy = mo_out || resp_now;
            x_gnt = x_busy ? onehot(mo_owner) : 2'b00;
            x_hold = mo_out;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
